uart_pwm_cmd_ctrl: RTL and testbench

Parametrised command parser and multi-channel PWM engine, fed by the UART receiver's byte stream. Parses ASCII lines of the form letter plus decimal digits, repeated, terminated by LF (e.g. "R12G200B3\n"). Duty values are held in shadow registers and committed atomically at a PWM period boundary. Received bytes are optionally echoed back to the UART transmitter. Sits between uart_rx/uart_tx and the top-level PWM pins, and generalises the fixed RGB, single-digit flow.

---
 rtl/uart_pwm_pkg.sv | 44 ++++
 rtl/uart_pwm_cmd_ctrl_pwm_gen.sv | 47 ++++
 rtl/uart_pwm_cmd_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_uart_pwm_cmd_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pwm_pkg.sv
// Shared constants, parser state and channel lookup
// for the UART-driven PWM command controller.
package uart_pwm_pkg;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;

  localparam int MAX_CH = 8;

  // Entry i is the letter selecting channel i.
  localparam logic [8*MAX_CH-1:0] CH_LETTERS = "RGBWACDE";

  typedef enum logic [1:0] {
    IDLE,
    DIGITS,
    DISCARD,
    COMMIT
  } parse_state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } ch_sel_t;

  // Map a byte to a channel index; only the first num_ch letters count.
  function automatic ch_sel_t letter_to_ch(
    input logic [7:0] b,
    input int         num_ch
  );
    ch_sel_t r;
    r = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (i < num_ch && !r.valid &&
          CH_LETTERS[8*(MAX_CH-1-i) +: 8] == b) begin
        r.valid = 1'b1;
        r.idx   = 3'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_pwm_cmd_ctrl_pwm_gen.sv
// PWM timebase: prescaler, free-running counter,
// wrap tick and per-channel registered comparators.
module pwm_gen
  import uart_pwm_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int DUTY_W = 8,
  parameter int DIV    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DUTY_W-1:0] duty,
  output logic [NUM_CH-1:0]        pwm_out,
  output logic                     wrap
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0]     presc;
  logic [DUTY_W-1:0] cnt;
  logic              tick;

  assign tick = (presc == PW'(DIV - 1));
  assign wrap = tick && (cnt == {DUTY_W{1'b1}});

  // Prescaler and period counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      cnt   <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) cnt <= cnt + DUTY_W'(1);
    end
  end

  // Registered compare per channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        pwm_out[i] <= (cnt < duty[i*DUTY_W +: DUTY_W]);
    end
  end

endmodule

// File: rtl/uart_pwm_cmd_ctrl.sv
// Line parser, shadow/active duty registers and echo.
// Optional ECHO_EN: 1-entry echo buffer toward uart_tx.
module uart_pwm_cmd_ctrl
  import uart_pwm_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int DUTY_W     = 8,
  parameter int MAX_DIGITS = 3,
  parameter int DIV        = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  input  logic                     tx_ready,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  output logic [NUM_CH-1:0]        pwm_out,
  output logic [NUM_CH*DUTY_W-1:0] duty,
  output logic                     done,
  output logic                     err
);

  localparam int NW = $clog2(MAX_DIGITS + 1);
  localparam logic [DUTY_W-1:0] DMAX = {DUTY_W{1'b1}};

  parse_state_t      state, state_n;
  logic [2:0]        ch, ch_n;
  logic [DUTY_W-1:0] acc, acc_n;
  logic [NW-1:0]     ndig, ndig_n;
  logic              act, act_n;
  logic              store, commit, restore, err_n;

  logic [DUTY_W-1:0] duty_r [NUM_CH];
  logic [DUTY_W-1:0] shadow [NUM_CH];
  logic [NUM_CH-1:0] dirty;

  logic              wrap;
  logic              byte_v, is_lf, is_dig;
  logic [3:0]        dig;
  logic [DUTY_W+3:0] prod;
  ch_sel_t           sel;

  assign byte_v = rx_valid && (rx_data != ASCII_CR);
  assign is_lf  = (rx_data == ASCII_LF);
  assign is_dig = (rx_data >= ASCII_0) && (rx_data <= ASCII_9);
  assign dig    = rx_data[3:0];
  assign sel    = letter_to_ch(rx_data, NUM_CH);
  assign prod   = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) +
                  {{DUTY_W{1'b0}}, dig};

  assign done = (state == IDLE);

  // Next-state, accumulator and register-update strobes.
  always_comb begin
    state_n = state;
    ch_n    = ch;
    acc_n   = acc;
    ndig_n  = ndig;
    act_n   = act;
    store   = 1'b0;
    commit  = 1'b0;
    restore = 1'b0;
    err_n   = 1'b0;
    if (byte_v) begin
      unique case (state)
        IDLE: begin
          if (sel.valid) begin
            state_n = DIGITS;
            ch_n    = sel.idx;
            acc_n   = '0;
            ndig_n  = '0;
          end else if (!is_lf) begin
            state_n = DISCARD;
            err_n   = 1'b1;
          end
        end
        DISCARD: begin
          if (is_lf) begin
            restore = 1'b1;
            state_n = IDLE;
          end
        end
        DIGITS, COMMIT: begin
          // In COMMIT a new line may start before the wrap.
          if (state == COMMIT && !act) begin
            if (sel.valid) begin
              act_n  = 1'b1;
              ch_n   = sel.idx;
              acc_n  = '0;
              ndig_n = '0;
            end else begin
              state_n = DISCARD;
              err_n   = 1'b1;
            end
          end else if (is_dig) begin
            if (ndig == NW'(MAX_DIGITS)) begin
              state_n = DISCARD;
              err_n   = 1'b1;
            end else begin
              acc_n  = (prod > {4'b0, DMAX}) ? DMAX
                                             : prod[DUTY_W-1:0];
              ndig_n = ndig + NW'(1);
            end
          end else if (sel.valid && ndig != '0) begin
            store  = 1'b1;
            ch_n   = sel.idx;
            acc_n  = '0;
            ndig_n = '0;
          end else if (is_lf && ndig != '0 &&
                       state == DIGITS) begin
            store   = 1'b1;
            state_n = COMMIT;
            act_n   = 1'b0;
          end else begin
            state_n = DISCARD;
            err_n   = 1'b1;
          end
        end
      endcase
      if (state_n == DISCARD) act_n = 1'b0;
    end
    if (state == COMMIT && wrap && state_n == COMMIT) begin
      commit  = 1'b1;
      state_n = act_n ? DIGITS : IDLE;
    end
  end

  // Parser registers, shadow and active duty banks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ch    <= '0;
      acc   <= '0;
      ndig  <= '0;
      act   <= 1'b0;
      err   <= 1'b0;
      dirty <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_r[i] <= '0;
        shadow[i] <= '0;
      end
    end else begin
      state <= state_n;
      ch    <= ch_n;
      acc   <= acc_n;
      ndig  <= ndig_n;
      act   <= act_n;
      err   <= err_n;
      if (restore) begin
        dirty <= '0;
        for (int i = 0; i < NUM_CH; i++)
          shadow[i] <= duty_r[i];
      end
      if (commit) begin
        dirty <= '0;
        for (int i = 0; i < NUM_CH; i++)
          if (dirty[i]) duty_r[i] <= shadow[i];
      end
      if (store) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch == 3'(i)) begin
            shadow[i] <= acc;
            dirty[i]  <= 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_duty
    assign duty[g*DUTY_W +: DUTY_W] = duty_r[g];
  end

  pwm_gen #(
    .NUM_CH (NUM_CH),
    .DUTY_W (DUTY_W),
    .DIV    (DIV)
  ) u_pwm (
    .clk     (clk),
    .rst     (rst),
    .duty    (duty),
    .pwm_out (pwm_out),
    .wrap    (wrap)
  );

`ifdef ECHO_EN
  // One-entry echo buffer; bytes arriving while full are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (!tx_valid && rx_valid) begin
      tx_valid <= 1'b1;
      tx_data  <= rx_data;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end
`else
  logic unused_tx_ready;
  assign unused_tx_ready = tx_ready;
  assign tx_valid = 1'b0;
  assign tx_data  = '0;
`endif

endmodule

// File: tb/tb_uart_pwm_cmd_ctrl.sv
// Bench for uart_pwm_cmd_ctrl: line-level reference model,
// per-cycle compare, directed literals and random lines.
module tb_uart_pwm_cmd_ctrl;

  localparam int NUM_CH = 3;
  localparam int DUTY_W = 8;
  localparam int MAXD   = 3;
  localparam logic [7:0] LF = 8'h0A;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     rx_valid;
  logic [7:0]               rx_data;
  logic                     tx_ready;
  logic                     tx_valid;
  logic [7:0]               tx_data;
  logic [NUM_CH-1:0]        pwm_out;
  logic [NUM_CH*DUTY_W-1:0] duty;
  logic                     done;
  logic                     err;

  always #5 clk = ~clk;

  uart_pwm_cmd_ctrl #(
    .NUM_CH     (NUM_CH),
    .DUTY_W     (DUTY_W),
    .MAX_DIGITS (MAXD),
    .DIV        (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .pwm_out  (pwm_out),
    .duty     (duty),
    .done     (done),
    .err      (err)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_err_obs = 0;

  // Reference model state.
  string             tbl = "RGBWACDE";
  int                k;
  int                m_duty [NUM_CH];
  int                p_val  [NUM_CH];
  bit                p_mask [NUM_CH];
  bit                m_pend;
  bit                disc;
  bit                m_err;
  logic [NUM_CH-1:0] m_pwm;
  logic [7:0]        line [$];
  bit                e_v;
  logic [7:0]        e_d;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int ch_of(input logic [7:0] b);
    for (int i = 0; i < NUM_CH; i++)
      if (tbl[i] == b) return i;
    return -1;
  endfunction

  function automatic bit is_digit(input logic [7:0] b);
    return b >= 8'h30 && b <= 8'h39;
  endfunction

  // True when q cannot be the start of a well-formed line.
  function automatic bit prefix_bad(input logic [7:0] q[$]);
    int run = 0;
    bit have = 0;
    foreach (q[j]) begin
      if (ch_of(q[j]) >= 0) begin
        if (j > 0 && run == 0) return 1;
        run  = 0;
        have = 1;
      end else if (is_digit(q[j])) begin
        if (!have) return 1;
        run++;
        if (run > MAXD) return 1;
      end else begin
        return 1;
      end
    end
    return 0;
  endfunction

  task automatic line_error();
    m_err  = 1;
    disc   = 1;
    m_pend = 0;
    line.delete();
    for (int i = 0; i < NUM_CH; i++) p_mask[i] = 0;
  endtask

  // Values of a complete line: last value per channel wins.
  task automatic eval_line();
    int c = -1;
    int v = 0;
    foreach (line[j]) begin
      if (ch_of(line[j]) >= 0) begin
        if (c >= 0) begin
          p_val[c]  = (v > 255) ? 255 : v;
          p_mask[c] = 1;
        end
        c = ch_of(line[j]);
        v = 0;
      end else begin
        v = v * 10 + int'(line[j]) - 48;
      end
    end
    p_val[c]  = (v > 255) ? 255 : v;
    p_mask[c] = 1;
  endtask

  task automatic byte_step(input logic [7:0] b);
    if (disc) begin
      if (b == LF) disc = 0;
    end else if (b == LF) begin
      if (line.size() == 0 && !m_pend) begin
      end else if (m_pend || ch_of(line[$]) >= 0) begin
        line_error();
      end else begin
        eval_line();
        m_pend = 1;
        line.delete();
      end
    end else begin
      line.push_back(b);
      if (prefix_bad(line)) line_error();
    end
  endtask

  task automatic model_step();
    if (rst) begin
      k = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_duty[i] = 0;
        p_mask[i] = 0;
      end
      m_pend = 0;
      disc   = 0;
      m_err  = 0;
      m_pwm  = '0;
      e_v    = 0;
      e_d    = '0;
      line.delete();
      return;
    end
    for (int i = 0; i < NUM_CH; i++)
      m_pwm[i] = ((k % 256) < m_duty[i]);
    m_err = 0;
    if (m_pend && (k % 256) == 255) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (p_mask[i]) m_duty[i] = p_val[i];
        p_mask[i] = 0;
      end
      m_pend = 0;
    end
    if (!e_v && rx_valid) begin
      e_v = 1;
      e_d = rx_data;
    end else if (e_v && tx_ready) begin
      e_v = 0;
    end
    if (rx_valid && rx_data != 8'h0D) byte_step(rx_data);
    k++;
  endtask

  // One clock: model update at the edge, compare 1ns later.
  task automatic tick();
    logic [31:0] exp_duty;
    @(posedge clk);
    model_step();
    #1;
    exp_duty = '0;
    for (int i = 0; i < NUM_CH; i++)
      exp_duty[i*DUTY_W +: DUTY_W] = DUTY_W'(m_duty[i]);
    chk("duty", 32'(duty), exp_duty);
    chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
    chk("err", 32'(err), 32'(m_err));
    chk("done", 32'(done),
        32'(line.size() == 0 && !disc && !m_pend));
`ifdef ECHO_EN
    chk("tx_valid", 32'(tx_valid), 32'(e_v));
    chk("tx_data", 32'(tx_data), 32'(e_d));
`else
    chk("tx_valid", 32'(tx_valid), 32'd0);
    chk("tx_data", 32'(tx_data), 32'd0);
`endif
    if (err === 1'b1) n_err_obs++;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_idle();
    int b = 0;
    if (disc) send_byte(LF);
    while ((m_pend || line.size() != 0) && b < 700) begin
      tick();
      b++;
    end
    chk("commit_bound", 32'(b < 700), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  int e0;
  int ones [NUM_CH];
  logic [7:0] q [$];
  logic [7:0] junk [5] = '{8'h78, 8'h72, 8'h57, 8'h20, 8'h35};

  task automatic count_high();
    for (int i = 0; i < NUM_CH; i++) ones[i] = 0;
    repeat (256) begin
      tick();
      for (int i = 0; i < NUM_CH; i++) ones[i] += int'(pwm_out[i]);
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    tx_ready = 1'b1;
    do_reset();
    chk("rst_duty", 32'(duty), 32'd0);
    chk("rst_done", 32'(done), 32'd1);
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    e0 = n_err_obs;
    send_str("R1G2B3\n");
    wait_idle();
    chk("rgb123_duty", 32'(duty), 32'h030201);
    chk("rgb123_done", 32'(done), 32'd1);
    chk("rgb123_noerr", 32'(n_err_obs - e0), 32'd0);
    count_high();
    chk("r1_high", 32'(ones[0]), 32'd1);

    send_str("R255G0B128\n");
    wait_idle();
    chk("mix_duty", 32'(duty), 32'h8000FF);
    count_high();
    chk("r255_high", 32'(ones[0]), 32'd255);
    chk("g0_high", 32'(ones[1]), 32'd0);
    chk("b128_high", 32'(ones[2]), 32'd128);

    send_str("R999\n");
    wait_idle();
    chk("r999_sat", 32'(duty), 32'h8000FF);

    e0 = n_err_obs;
    send_str("R1234\n");
    wait_idle();
    chk("r1234_err", 32'(n_err_obs - e0), 32'd1);
    chk("r1234_keep", 32'(duty), 32'h8000FF);
    send_str("G5\n");
    wait_idle();
    chk("g5_only", 32'(duty), 32'h8005FF);

    e0 = n_err_obs;
    send_str("RXG2\n");
    wait_idle();
    chk("rx_err", 32'(n_err_obs - e0), 32'd1);
    chk("rx_keep", 32'(duty), 32'h8005FF);
    e0 = n_err_obs;
    send_str("\n\n");
    chk("empty_noerr", 32'(n_err_obs - e0), 32'd0);
    chk("empty_done", 32'(done), 32'd1);

`ifdef ECHO_EN
    tx_ready = 1'b0;
    send_byte(8'h47);
    send_byte(8'h39);
    chk("echo_valid", 32'(tx_valid), 32'd1);
    chk("echo_first", 32'(tx_data), 32'h47);
    tx_ready = 1'b1;
    tick();
    chk("echo_drain", 32'(tx_valid), 32'd0);
    send_byte(LF);
    wait_idle();
    chk("echo_commit", 32'(duty), 32'h8009FF);
`endif

    send_str("R12");
    do_reset();
    chk("midrst_duty", 32'(duty), 32'd0);
    chk("midrst_done", 32'(done), 32'd1);
    send_str("B7\n");
    wait_idle();
    chk("b7_only", 32'(duty), 32'h070000);

    for (int n = 0; n < 40; n++) begin
      int r;
      q.delete();
      r = $urandom_range(0, 9);
      tx_ready = 1'($urandom_range(0, 1));
      if (r != 0) begin
        for (int t = 0; t < $urandom_range(1, 3); t++) begin
          q.push_back(tbl[$urandom_range(0, NUM_CH - 1)]);
          for (int d = 0; d < $urandom_range(1, 3); d++)
            q.push_back(8'h30 + 8'($urandom_range(0, 9)));
        end
        if (r == 1)
          q.insert($urandom_range(0, q.size() - 1),
                   junk[$urandom_range(0, 4)]);
        if (r == 2)
          q.insert($urandom_range(0, q.size() - 1), 8'h0D);
      end
      q.push_back(LF);
      foreach (q[j]) send_byte(q[j]);
      wait_idle();
      tx_ready = 1'b1;
      repeat ($urandom_range(0, 5)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
